// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter between the L1 I-cache and D-cache in front
// of the shared L2 controller. It keeps one request in flight, routes the L2
// completion back to the owner, and keeps a saturating grant count per requester.

// Saturating grant counter, one instance per requester.
module l2_arb_grant_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bump on grant; once at all-ones, stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // L2 controller side
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  // Statistics
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);
  localparam int NUM_REQ = 2;
  localparam int REQ_I   = 0;
  localparam int REQ_D   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  // Latched request presented to L2 for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              op;     // 1 = write-back, 0 = line read
  } req_t;

  state_e                        state_q, state_d;
  logic                          prio_q, prio_d;
  req_t                          req_q, req_d;
  logic                          d_req;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt;

  assign d_req = d_read | d_write;

  // Grant decode: only from IDLE; prio breaks a tie (0 = I first, 1 = D first).
  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      grant[REQ_I] = i_read & (~d_req | ~prio_q);
      grant[REQ_D] = d_req & (~i_read | prio_q);
    end
  end

  // State and priority registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next state: hold while busy until l2_resp, then hand priority to the other side.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (grant[REQ_I])      state_d = BUSY_I;
        else if (grant[REQ_D]) state_d = BUSY_D;
      end
      BUSY_I: begin
        if (l2_resp) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      BUSY_D: begin
        if (l2_resp) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's request at grant; requester inputs are ignored while busy.
  always_comb begin
    req_d = req_q;
    if (grant[REQ_I]) begin
      req_d.addr = i_addr;
      req_d.op   = 1'b0;
    end else if (grant[REQ_D]) begin
      req_d.addr  = d_addr;
      req_d.wdata = d_wdata;
      req_d.op    = d_write;   // write wins over a simultaneous read
    end
  end

  // Request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req_d;
  end

  // Outputs: L2 request while busy, completion strobe routed to the owner.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state_q)
      BUSY_I: begin
        l2_read = 1'b1;
        i_resp  = l2_resp;
      end
      BUSY_D: begin
        l2_read  = ~req_q.op;
        l2_write = req_q.op;
        d_resp   = l2_resp;
      end
      default: ;
    endcase
  end

  assign l2_addr  = req_q.addr;
  assign l2_wdata = req_q.wdata;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;

  // Per-requester grant counters.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    l2_arb_grant_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant[g]),
      .cnt   (grant_cnt[g])
    );
  end

  assign i_grant_cnt = grant_cnt[REQ_I];
  assign d_grant_cnt = grant_cnt[REQ_D];
endmodule
